// File: rtl/wb_block_master.sv
// wb_block_master: Wishbone classic block initiator.
// Moves cmd_len 32-bit words between a local stream and a Wishbone slave,
// one single-beat cycle per word, address stepping by 4 (wraps mod 2^ADDR_W).
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_write/addr/len        direction (1=write), start byte address, words
//   wr_valid/wr_ready/wr_data write-data stream into the master
//   rd_valid/rd_ready/rd_data read-data stream out of the master
//   wbm_*                     Wishbone classic master signals
//   busy_o, done_o, err_o     status; done/err are one-cycle pulses
//
// Build option: define WB_MASTER_ERR_EN to abort a command on wbm_err_i.
// Without it wbm_err_i is ignored and only the ack timeout aborts.
module wb_block_master #(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    input  logic [31:0]       wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    input  logic              rd_ready,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_REQ,
        S_DRAIN,
        S_DONE,
        S_ABORT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  left_q, left_d;
    logic              we_q, we_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [31:0]       rdat_q, rdat_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic bus_err;
    logic tmo_hit;

    // Bus address always word aligned; the low byte-offset bits are dropped.
    logic [1:0] unused_addr;
    assign unused_addr = cmd_addr[1:0];

`ifdef WB_MASTER_ERR_EN
    assign bus_err = wbm_err_i;
`else
    logic unused_err;
    assign unused_err = wbm_err_i;
    assign bus_err    = 1'b0;
`endif

    // tmo_q counts REQ cycles already spent without ack, so the beat is
    // given exactly TIMEOUT cycles of stb before it is abandoned.
    if (TIMEOUT == 0) begin : g_no_tmo
        assign tmo_hit = 1'b0;
    end else begin : g_tmo
        assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        tmo_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d = {cmd_addr[ADDR_W-1:2], 2'b00};
                    left_d = cmd_len;
                    we_d   = cmd_write;
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end else if (cmd_write) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_FETCH: begin
                if (wr_valid) begin
                    wdat_d  = wr_data;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // err outranks ack; ack outranks an expiring timer.
                if (bus_err) begin
                    state_d = S_ABORT;
                end else if (wbm_ack_i) begin
                    addr_d = addr_q + ADDR_W'(4);
                    left_d = left_q - LEN_W'(1);
                    if (!we_q) begin
                        rdat_d  = wbm_dat_i;
                        state_d = S_DRAIN;
                    end else if (left_q != LEN_W'(1)) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ABORT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DRAIN: begin
                if (rd_ready) begin
                    state_d = (left_q != '0) ? S_REQ : S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy_o    = (state_q != S_IDLE);
    assign wr_ready  = (state_q == S_FETCH);
    assign rd_valid  = (state_q == S_DRAIN);
    assign done_o    = (state_q == S_DONE);
    assign err_o     = (state_q == S_ABORT);
    assign wbm_stb_o = (state_q == S_REQ);
    assign wbm_cyc_o = (state_q == S_FETCH) ||
                       (state_q == S_REQ)   ||
                       (state_q == S_DRAIN);
    assign wbm_we_o  = we_q & wbm_cyc_o;
    assign wbm_sel_o = 4'hF;
    assign wbm_adr_o = addr_q;
    assign wbm_dat_o = wdat_q;
    assign rd_data   = rdat_q;

endmodule

// File: tb/tb_wb_block_master.sv
// tb_wb_block_master: randomized bench for wb_block_master.
// Behavioural slave and streams; per-command expectations from the block rules.
module tb_wb_block_master;

    localparam int TMO = 8;

    logic        clk;
    logic        wb_rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    wb_block_master #(
        .ADDR_W (32),
        .LEN_W  (8),
        .TIMEOUT(TMO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_pass;

    logic [31:0] b_adr[$];
    logic [31:0] b_wd[$];
    logic [31:0] b_rd[$];
    bit          b_we[$];
    logic [31:0] wr_sent[$];
    logic [31:0] rd_got[$];

    int n_done, n_err, tick_n;
    int first_stb, first_rdv, done_tick, err_tick;
    int stb_cnt, cyc_cnt, beat_idx;
    int ack_wait, wr_pct, rd_pct, wr_gap, gap_cnt;
    int rd_stall, err_beat, cur_wait, wait_cnt;
    bit in_cmd, stb_acked, stb_pend, rd_hold;
    logic [31:0] prev_adr, prev_rd;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h",
                      tag, got, exp);
    endtask

    task automatic tick();
        bit err_ab;
        @(negedge clk);
        if (in_cmd) begin
            chk("busy", 32'(busy_o), 32'd1);
            chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        end
        if (wbm_stb_o) begin
            chk("stb_cyc", 32'(wbm_cyc_o), 32'd1);
            chk("sel", 32'(wbm_sel_o), 32'hF);
            stb_cnt++;
            if (first_stb < 0) first_stb = tick_n;
        end
        if (wbm_cyc_o) cyc_cnt++;
        if (stb_acked) chk("stb_gap", 32'(wbm_stb_o), 32'd0);
        if (wbm_stb_o && stb_pend)
            chk("adr_hold", wbm_adr_o, prev_adr);
        if (rd_hold) chk("rd_hold", rd_data, prev_rd);
        if (rd_valid) begin
            chk("drain_stb", 32'(wbm_stb_o), 32'd0);
            chk("drain_cyc", 32'(wbm_cyc_o), 32'd1);
            if (first_rdv < 0) first_rdv = tick_n;
        end
        if (wr_ready) chk("fetch_stb", 32'(wbm_stb_o), 32'd0);
        if (done_o || err_o) chk("end_cyc", 32'(wbm_cyc_o), 32'd0);
        if (done_o) begin n_done++; done_tick = tick_n; end
        if (err_o) begin n_err++; err_tick = tick_n; end

        // slave: per-beat wait, then ack (optionally with err)
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = $urandom;
        if (wbm_stb_o) begin
            if (!stb_pend) begin
                cur_wait = (ack_wait < 0) ? $urandom_range(0, 3)
                                          : ack_wait;
                wait_cnt = 0;
            end
            if (wait_cnt >= cur_wait) begin
                wbm_ack_i = 1'b1;
                if (beat_idx == err_beat) wbm_err_i = 1'b1;
            end else begin
                wait_cnt++;
            end
        end
        err_ab = 1'b0;
`ifdef WB_MASTER_ERR_EN
        err_ab = wbm_err_i;
`endif
        if (wbm_stb_o && wbm_ack_i) begin
            if (!err_ab) begin
                b_adr.push_back(wbm_adr_o);
                b_we.push_back(wbm_we_o);
                b_wd.push_back(wbm_dat_o);
                b_rd.push_back(wbm_dat_i);
            end
            beat_idx++;
        end
        stb_acked = wbm_stb_o && wbm_ack_i;
        stb_pend  = wbm_stb_o && !wbm_ack_i;
        prev_adr  = wbm_adr_o;

        // write stream
        wr_valid = 1'b0;
        if (wr_gap >= 0) begin
            if (wr_ready) begin
                if (gap_cnt < wr_gap) gap_cnt++;
                else wr_valid = 1'b1;
            end
        end else begin
            wr_valid = ($urandom_range(0, 99) < wr_pct);
        end
        wr_data = $urandom;
        if (wr_valid && wr_ready) begin
            wr_sent.push_back(wr_data);
            gap_cnt = 0;
        end

        // read stream
        if (rd_valid && rd_stall > 0) begin
            rd_ready = 1'b0;
            rd_stall--;
        end else begin
            rd_ready = ($urandom_range(0, 99) < rd_pct);
        end
        if (rd_valid && rd_ready) rd_got.push_back(rd_data);
        rd_hold = rd_valid && !rd_ready;
        prev_rd = rd_data;

        // junk commands while busy must be refused
        cmd_valid = in_cmd ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_len   = 8'($urandom);
        tick_n++;
    endtask

    task automatic run_cmd(input bit wr, input logic [31:0] a,
                           input logic [7:0] l, input int exp_beats,
                           input bit exp_done);
        logic [31:0] base;
        bit fin;
        @(negedge clk);
        chk("idle_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy_o), 32'd0);
        b_adr.delete(); b_wd.delete(); b_rd.delete(); b_we.delete();
        wr_sent.delete(); rd_got.delete();
        n_done = 0; n_err = 0; first_stb = -1; first_rdv = -1;
        done_tick = -1; err_tick = -1; stb_cnt = 0; cyc_cnt = 0;
        beat_idx = 0; gap_cnt = 0;
        stb_acked = 0; stb_pend = 0; rd_hold = 0;
        wbm_ack_i = 0; wbm_err_i = 0; wr_valid = 0; rd_ready = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        in_cmd = 1; tick_n = 0; fin = 0;
        while (!fin && tick_n < 300) begin
            tick();
            if (n_done + n_err > 0) fin = 1;
        end
        in_cmd = 0; cmd_valid = 0; wr_valid = 0; rd_ready = 0;
        wbm_ack_i = 0; wbm_err_i = 0;
        chk("cmd_end", 32'(fin), 32'd1);
        base = a & ~32'h3;
        chk("beats", 32'(b_adr.size()), 32'(exp_beats));
        foreach (b_adr[i]) begin
            chk("adr", b_adr[i], base + 32'(4 * i));
            chk("we", 32'(b_we[i]), 32'(wr));
            if (wr && i < wr_sent.size())
                chk("wdat", b_wd[i], wr_sent[i]);
        end
        if (wr && exp_done)
            chk("nsent", 32'(wr_sent.size()), 32'(exp_beats));
        if (!wr) begin
            chk("nrd", 32'(rd_got.size()), 32'(exp_beats));
            foreach (rd_got[i])
                if (i < b_rd.size()) chk("rdat", rd_got[i], b_rd[i]);
        end
        chk("done", 32'(n_done), 32'(exp_done));
        chk("err", 32'(n_err), 32'(!exp_done));
    endtask

    task automatic knobs(input int aw, input int wp, input int rp,
                         input int wg, input int rs, input int eb);
        ack_wait = aw; wr_pct = wp; rd_pct = rp;
        wr_gap = wg; rd_stall = rs; err_beat = eb;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; in_cmd = 0;
        wb_rst_i = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
        cmd_len = 0; wr_valid = 0; wr_data = 0; rd_ready = 0;
        wbm_dat_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
        knobs(0, 100, 100, -1, 0, -1);
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_we", 32'(wbm_we_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        wb_rst_i = 0;

        // read len=1 latency, zero-wait slave
        knobs(0, 100, 100, -1, 0, -1);
        run_cmd(0, 32'h3200_0000, 8'd1, 1, 1);
        chk("lat_stb", 32'(first_stb), 32'd0);
        chk("lat_rdv", 32'(first_rdv), 32'd1);
        chk("lat_done", 32'(done_tick), 32'd2);

        // read len=3 zero-wait
        run_cmd(0, 32'h3200_0000, 8'd3, 3, 1);

        // write len=2 with 5-cycle gaps on wr_valid
        knobs(0, 100, 100, 5, 0, -1);
        run_cmd(1, 32'h3200_0010, 8'd2, 2, 1);

        // read len=2, consumer stalls 4 cycles
        knobs(0, 100, 100, -1, 4, -1);
        run_cmd(0, 32'h3200_0020, 8'd2, 2, 1);

        // empty command
        knobs(0, 100, 100, -1, 0, -1);
        run_cmd(0, 32'h3200_0030, 8'd0, 0, 1);
        chk("len0_done", 32'(done_tick), 32'd0);
        chk("len0_cyc", 32'(cyc_cnt), 32'd0);
        run_cmd(1, 32'h3200_0030, 8'd0, 0, 1);
        chk("len0w_cyc", 32'(cyc_cnt), 32'd0);

        // address wrap
        run_cmd(1, 32'hFFFF_FFFC, 8'd2, 2, 1);
        run_cmd(0, 32'hFFFF_FFFE, 8'd2, 2, 1);

        // timeout: slave never acks
        knobs(1000, 100, 100, -1, 0, -1);
        run_cmd(0, 32'h3200_0040, 8'd2, 0, 0);
        chk("tmo_stb_cycles", 32'(stb_cnt), 32'(TMO));
        chk("tmo_err_tick", 32'(err_tick), 32'(TMO));
        run_cmd(1, 32'h3200_0040, 8'd1, 0, 0);
        chk("tmo_w_stb_cycles", 32'(stb_cnt), 32'(TMO));

        // ack on the last allowed cycle wins
        knobs(TMO - 1, 100, 100, -1, 0, -1);
        run_cmd(0, 32'h3200_0050, 8'd1, 1, 1);
        chk("tmo_edge_stb", 32'(stb_cnt), 32'(TMO));

        // bus error on beat 2 of 4
        knobs(0, 100, 100, -1, 0, 1);
`ifdef WB_MASTER_ERR_EN
        run_cmd(0, 32'h3200_0100, 8'd4, 1, 0);
        run_cmd(1, 32'h3200_0100, 8'd4, 1, 0);
`else
        run_cmd(0, 32'h3200_0100, 8'd4, 4, 1);
        run_cmd(1, 32'h3200_0100, 8'd4, 4, 1);
`endif

        // reset in the middle of a REQ
        @(negedge clk);
        wbm_ack_i = 0; wbm_err_i = 0;
        cmd_valid = 1; cmd_write = 0;
        cmd_addr = 32'h3200_0200; cmd_len = 8'd3;
        @(negedge clk);
        cmd_valid = 0;
        chk("mid_rst_stb", 32'(wbm_stb_o), 32'd1);
        repeat (2) @(negedge clk);
        chk("mid_rst_cyc", 32'(wbm_cyc_o), 32'd1);
        wb_rst_i = 1;
        @(negedge clk);
        wb_rst_i = 0;
        chk("after_rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("after_rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("after_rst_busy", 32'(busy_o), 32'd0);
        chk("after_rst_ready", 32'(cmd_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("after_rst_done", 32'(done_o), 32'd0);
            chk("after_rst_err", 32'(err_o), 32'd0);
        end

        // randomized commands
        for (int k = 0; k < 30; k++) begin
            logic [31:0] a;
            logic [7:0]  l;
            bit          w;
            knobs(-1, 70, 60, -1, $urandom_range(0, 2), -1);
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 3) == 0)
                a = 32'hFFFF_FFE0 | (a & 32'h1F);
            l = 8'($urandom_range(0, 6));
            run_cmd(w, a, l, int'(l), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
